// File: rtl/fp_pkg.sv
// Shared single-precision field definitions, constants and flag positions
// used by the adder wrapper stage and its result buffer.
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  localparam logic [31:0]      QNAN    = 32'h7FC00000;
  localparam logic [EXP_W-1:0] INF_EXP = 8'hFF;

  localparam int FLG_INV  = 0;
  localparam int FLG_OVF  = 1;
  localparam int FLG_ZERO = 2;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp_fields_t;

  function automatic fp_fields_t unpackFp(input logic [31:0] x);
    fp_fields_t f;
    f = x;
    return f;
  endfunction

endpackage

// File: rtl/fadd_rfifo.sv
// Synchronous result FIFO with occupancy count; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module fadd_rfifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 35
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wrPtr;
  logic [PW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;
  logic             w_doPush;
  logic             w_doPop;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_empty  = (r_count == '0);
  assign o_full   = (r_count == CW'(DEPTH));
  assign w_doPop  = i_pop & !o_empty;
  assign w_doPush = i_push & (!o_full | w_doPop);
  assign o_data   = r_mem[r_rdPtr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_mem[r_wrPtr] <= i_data;
        r_wrPtr        <= nextPtr(r_wrPtr);
      end
      if (w_doPop) r_rdPtr <= nextPtr(r_rdPtr);
      // Simultaneous push and pop leaves the occupancy unchanged.
      if (w_doPush && !w_doPop)      r_count <= r_count + 1'b1;
      else if (w_doPop && !w_doPush) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/fadd_stage.sv
// Operand/result pipeline stage around the external combinational adder:
// registers operands, patches IEEE special cases, buffers packed results.
module fadd_stage
  import fp_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_a,
  input  logic [31:0]       in_b,
  input  logic              in_op,
  output logic              fa_as,
  output logic              fa_bs,
  output logic [EXP_W-1:0]  fa_ae,
  output logic [EXP_W-1:0]  fa_be,
  output logic [MAN_W-1:0]  fa_a,
  output logic [MAN_W-1:0]  fa_b,
  input  logic              fa_rs,
  input  logic [EXP_W-1:0]  fa_re,
  input  logic [MAN_W-1:0]  fa_r,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_r,
  output logic [2:0]        out_flags
);

  fp_fields_t       r_a;
  fp_fields_t       r_b;
  logic             r_s1Valid;

  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_advance;
  logic             w_load;
  logic [31:0]      w_res;
  logic [2:0]       w_flags;
  logic [34:0]      w_head;
  logic             w_aNan, w_bNan, w_aInf, w_bInf, w_aZero, w_bZero;
  logic [EXP_W-1:0] w_maxExp;

  assign w_pop     = !w_empty & out_ready;
  assign w_advance = r_s1Valid & (!w_full | w_pop);
  assign in_ready  = !r_s1Valid | w_advance;
  assign w_load    = in_valid & in_ready;

  // B's sign is flipped at capture so everything downstream sees an addition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_s1Valid <= 1'b0;
    end else if (w_load) begin
      r_a       <= unpackFp(in_a);
      r_b       <= unpackFp({in_b[31] ^ in_op, in_b[30:0]});
      r_s1Valid <= 1'b1;
    end else if (w_advance) begin
      r_s1Valid <= 1'b0;
    end
  end

  assign fa_as = r_a.sign;
  assign fa_bs = r_b.sign;
  assign fa_ae = r_a.exp;
  assign fa_be = r_b.exp;
  assign fa_a  = r_a.man;
  assign fa_b  = r_b.man;

  assign w_aNan   = (r_a.exp == INF_EXP) && (r_a.man != '0);
  assign w_bNan   = (r_b.exp == INF_EXP) && (r_b.man != '0);
  assign w_aInf   = (r_a.exp == INF_EXP) && (r_a.man == '0);
  assign w_bInf   = (r_b.exp == INF_EXP) && (r_b.man == '0);
  assign w_aZero  = (r_a.exp == '0);
  assign w_bZero  = (r_b.exp == '0);
  assign w_maxExp = (r_a.exp > r_b.exp) ? r_a.exp : r_b.exp;

  // Denormals count as zero; an exponent above both inputs on a true
  // subtraction means the adder's normalizer wrapped on a zero result.
  always_comb begin
    w_res   = {fa_rs, fa_re, fa_r};
    w_flags = '0;
    if (w_aNan || w_bNan) begin
      w_res            = QNAN;
      w_flags[FLG_INV] = 1'b1;
    end else if (w_aInf && w_bInf && (r_a.sign != r_b.sign)) begin
      w_res            = QNAN;
      w_flags[FLG_INV] = 1'b1;
    end else if (w_aInf) begin
      w_res = {r_a.sign, INF_EXP, {MAN_W{1'b0}}};
    end else if (w_bInf) begin
      w_res = {r_b.sign, INF_EXP, {MAN_W{1'b0}}};
    end else if (w_aZero && w_bZero) begin
      w_res             = {r_a.sign & r_b.sign, 31'd0};
      w_flags[FLG_ZERO] = 1'b1;
    end else if (w_aZero) begin
      w_res = r_b;
    end else if (w_bZero) begin
      w_res = r_a;
    end else if ((r_a.exp == r_b.exp) && (r_a.man == r_b.man) && (r_a.sign != r_b.sign)) begin
      w_res             = 32'd0;
      w_flags[FLG_ZERO] = 1'b1;
    end else if (fa_re == INF_EXP) begin
      w_res            = {fa_rs, 31'h7F800000};
      w_flags[FLG_OVF] = 1'b1;
    end else if ((r_a.sign != r_b.sign) && (fa_re > w_maxExp)) begin
      w_res             = 32'd0;
      w_flags[FLG_ZERO] = 1'b1;
    end
  end

  fadd_rfifo #(
    .DEPTH (DEPTH),
    .WIDTH (35)
  ) u_rfifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_advance),
    .i_data  ({w_res, w_flags}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign out_valid          = !w_empty;
  assign {out_r, out_flags} = w_head;

endmodule

// File: doc/fadd_stage.md
# fadd_stage

Pipelined operand/result stage wrapped around the combinational single-precision adder (`floadd`). It accepts packed IEEE-754 operand pairs over a valid/ready handshake and registers them into sign/exponent/mantissa fields that drive the adder. It captures the adder's outputs one cycle later, applies the special-case handling the adder does not perform, and buffers packed results toward the consumer.

## Interface
- `DEPTH`, default 2: result buffer entries, ≥1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: stage accepts this cycle.
- `in_a` in 32: operand A, packed IEEE single.
- `in_b` in 32: operand B, packed IEEE single.
- `in_op` in 1: 0 = A+B; 1 = A−B (B sign inverted at capture).
- `fa_as`/`fa_bs` out 1: signs to adder.
- `fa_ae`/`fa_be` out 8: exponents to adder.
- `fa_a`/`fa_b` out 23: mantissas to adder.
- `fa_rs` in 1, `fa_re` in 8, `fa_r` in 23: adder result fields.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts.
- `out_r` out 32: packed result.
- `out_flags` out 3: [0] invalid, [1] overflow, [2] zero result.

## Operation
- **S1 register:** holds `a` fields and effective `b` fields (`bs ^ in_op`), plus `s1_valid`. The `fa_*` outputs are driven directly from S1.
- **Special-case decode** is combinational from S1. Denormals (exp==0) are treated as zero. Checks apply in priority order:
  1. Either operand NaN (exp 255, mant≠0) → 0x7FC00000, invalid.
  2. Both inf with opposite effective signs → 0x7FC00000, invalid.
  3. Either operand inf → that inf with its effective sign.
  4. Both zero → sign = `as & bs_eff`, value ±0, zero flag.
  5. One zero → the other operand with its effective sign; zero flag only if that operand is also zero.
  6. Equal exponent and mantissa, opposite signs → 0x00000000, zero flag.
  7. Otherwise use the adder result `{fa_rs, fa_re, fa_r}`, with two overrides:
     - If `fa_re`==255 → `{fa_rs, 0x7F800000[30:0]}` (±inf), overflow flag.
     - If signs differ and `fa_re` > max(ae, be) (normalizer wrapped) → 0x00000000, zero flag.
- **Result buffer:** a FIFO of `DEPTH` entries holding {out_r, out_flags}. `out_r`/`out_flags` present the head entry; `out_valid` = not empty. Results leave in order.
- **Pipeline control:**
  - S1 advances (pushes into the FIFO) when `s1_valid` and (FIFO not full, or a pop happens this cycle).
  - `in_ready` = !`s1_valid` | S1 advances (combinational).
  - S1 loads on `in_valid & in_ready`. Otherwise it clears when it advances.

## Timing
- Latency: a pair accepted at edge N drives the adder from N; its result enters the FIFO at edge N+1. `out_valid` is high after N+1.
- Throughput is 1 per cycle with `out_ready` held high.
- Simultaneous push and pop when the FIFO is full is legal; count is unchanged.
- Backpressure: at most `DEPTH`+1 pairs are held (S1 plus FIFO) before `in_ready` falls. `in_ready` rises in the same cycle that `out_ready` pops.
- Reset (asynchronous, any time, including mid-stream): `s1_valid`=0, FIFO empty, FIFO pointers 0, `out_valid`=0, `out_r`=0, `out_flags`=0, `fa_*`=0. `in_ready`=1 while `rst` is low after reset. In-flight data is discarded.
- Inputs must be stable while `in_valid & !in_ready`. Once `out_valid` rises, the entry holds until `out_ready`.

## Structure
- Shared package `fp_pkg` holds:
  - Field widths: EXP_W=8, MAN_W=23.
  - Constants: QNAN=32'h7FC00000, INF_EXP=8'hFF.
  - Flag bit indices: FLG_INV=0, FLG_OVF=1, FLG_ZERO=2.
  - Typedef `fp_fields_t` {sign, exp, man}.
- One sub-module `fadd_rfifo`: parameterised synchronous FIFO with full/empty and simultaneous push/pop.
- Decode and pack logic stay in the top level.

## Test plan
- 0x3F800000 + 0x3F800000, op=0, `out_ready`=1 → 0x40000000, flags 0, `out_valid` one edge after accept.
- 0x3FC00000 − 0x3FC00000 (op=1) → 0x00000000, flags=3'b100.
- 0x7F800000 + 0xFF800000 → 0x7FC00000, flags=3'b001. Then 0x7FC00001 + 0x3F800000 → 0x7FC00000, flags=3'b001.
- 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, flags=3'b010. Then 0x00000000 + 0x40400000 → 0x40400000, flags 0.
- `DEPTH`=2, `out_ready`=0, four back-to-back pairs → `in_ready` falls after the 3rd accept. Raising `out_ready` drains the results in order and accepts the 4th pair.
- Assert `rst` while S1 and FIFO are occupied → `out_valid` falls immediately (asynchronously). After release, 0x40000000 + 0x40000000 → 0x40800000 with no stale outputs.
